// File: rtl/lbp_update_ctrl.sv
// Local-branch-predictor history table update controller.
// Clears the LHT, queues branch updates and arbitrates the table port.
module lbp_update_ctrl #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 7,
  parameter int unsigned VLEN       = 64,
  localparam int unsigned IDX_W     = $clog2(NR_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic [VLEN-1:0]      upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic                 lookup_req_i,
  output logic                 lookup_gnt_o,
  output logic                 tbl_req_o,
  output logic                 tbl_we_o,
  output logic [IDX_W-1:0]     tbl_addr_o,
  output logic [HIST_BITS-1:0] tbl_wdata_o,
  input  logic [HIST_BITS-1:0] tbl_rdata_i,
  output logic                 init_busy_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] init_q, init_d;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    starve_q, starve_d;

  logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic             fifo_tkn [FIFO_DEPTH];

  logic full, empty, push, pop, upd_sel, starve_max;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;

  logic unused_in;
  assign unused_in = ^{upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0],
                       tbl_rdata_i[HIST_BITS-1]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign empty      = (cnt_q == '0);
  assign starve_max = (starve_q == SW'(STARVE_MAX));
  assign head_idx   = fifo_idx[rd_q];
  assign head_tkn   = fifo_tkn[rd_q];

  assign upd_ready_o = !full && (state_q != S_INIT) && !flush_i;
  assign push        = upd_valid_i && upd_ready_o;

  always_comb begin
    tbl_req_o    = 1'b0;
    tbl_we_o     = 1'b0;
    tbl_addr_o   = '0;
    tbl_wdata_o  = '0;
    lookup_gnt_o = 1'b0;
    init_busy_o  = 1'b0;
    upd_sel      = 1'b0;
    pop          = 1'b0;
    state_d      = state_q;
    init_d       = init_q;
    unique case (1'b1)
      (state_q == S_INIT): begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = init_q;
        init_busy_o = 1'b1;
        init_d      = init_q + IDX_W'(1);
        if (init_q == IDX_W'(NR_ENTRIES - 1)) state_d = S_IDLE;
      end
      (state_q == S_IDLE): begin
        if (!empty && (!lookup_req_i || starve_max)) begin
          upd_sel    = 1'b1;
          tbl_req_o  = 1'b1;
          tbl_addr_o = head_idx;
          state_d    = S_WR;
        end else if (lookup_req_i) begin
          lookup_gnt_o = 1'b1;
        end
      end
      (state_q == S_WR): begin
        // a flush kills the write; the FIFO is discarded anyway
        tbl_req_o   = !flush_i;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = head_idx;
        tbl_wdata_o = {tbl_rdata_i[HIST_BITS-2:0], head_tkn};
        pop         = !flush_i;
        state_d     = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    if (flush_i) begin
      state_d = S_INIT;
      init_d  = '0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || upd_sel) starve_d = '0;
    else if (lookup_gnt_o && !starve_max) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_INIT;
      init_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      if (flush_i) begin
        wr_q     <= '0;
        rd_q     <= '0;
        cnt_q    <= '0;
        starve_q <= '0;
      end else begin
        starve_q <= starve_d;
        if (push) wr_q <= ptr_inc(wr_q);
        if (pop)  rd_q <= ptr_inc(rd_q);
        if (push && !pop) cnt_q <= cnt_q + CW'(1);
        else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_q] <= upd_pc_i[IDX_W:1];
      fifo_tkn[wr_q] <= upd_taken_i;
    end
  end

endmodule

// File: tb/tb_lbp_update_ctrl.sv
// Directed bench for lbp_update_ctrl with default parameters.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_lbp_update_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [63:0] upd_pc_i;
  logic        upd_taken_i;
  logic        lookup_req_i;
  logic        lookup_gnt_o;
  logic        tbl_req_o;
  logic        tbl_we_o;
  logic [5:0]  tbl_addr_o;
  logic [7:0]  tbl_wdata_o;
  logic [7:0]  tbl_rdata_i;
  logic        init_busy_o;

  int checks = 0;
  int failures = 0;

  lbp_update_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
    .tbl_req_o(tbl_req_o), .tbl_we_o(tbl_we_o),
    .tbl_addr_o(tbl_addr_o), .tbl_wdata_o(tbl_wdata_o),
    .tbl_rdata_i(tbl_rdata_i), .init_busy_o(init_busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {gnt, req, we, addr}
  function automatic logic [8:0] port();
    return {lookup_gnt_o, tbl_req_o, tbl_we_o, tbl_addr_o};
  endfunction

  // One full clear: 64 writes of zero, busy high, no grant or ready
  task automatic init_run(input string tag);
    for (int i = 0; i < 64; i++) begin
      #1;
      chk(tag, {init_busy_o, upd_ready_o, lookup_gnt_o, tbl_req_o,
                tbl_we_o, tbl_addr_o, tbl_wdata_o},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'(i), 8'h00});
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; upd_valid_i = 1'b0;
    upd_pc_i = '0; upd_taken_i = 1'b0; lookup_req_i = 1'b0;
    tbl_rdata_i = '0;
    @(negedge clk_i); #1;
    chk("rst_out", {init_busy_o, upd_ready_o, lookup_gnt_o, tbl_req_o,
                    tbl_we_o, tbl_addr_o, tbl_wdata_o},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 8'h00});
    @(negedge clk_i);
    rst_ni = 1'b1;
    init_run("init0");
    #1; chk("init_done", {init_busy_o, upd_ready_o}, 2'b01);

    // single update: read 0x08, then write shifted history
    upd_valid_i = 1'b1; upd_pc_i = 64'h8000_0010; upd_taken_i = 1'b1;
    #1; chk("push_rdy", upd_ready_o, 1'b1);
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    #1; chk("upd_rd", port(), {1'b0, 1'b1, 1'b0, 6'h08});
    @(negedge clk_i);
    tbl_rdata_i = 8'h5A;
    #1; chk("upd_wr", port(), {1'b0, 1'b1, 1'b1, 6'h08});
    chk("upd_wd", tbl_wdata_o, 8'hB5);
    @(negedge clk_i);
    tbl_rdata_i = 8'h00;
    #1; chk("idle_quiet", tbl_req_o, 1'b0);

    // back-to-back not-taken updates to the same index
    upd_valid_i = 1'b1; upd_pc_i = 64'h10; upd_taken_i = 1'b0;
    @(negedge clk_i);
    #1; chk("b2b_rd1", port(), {1'b0, 1'b1, 1'b0, 6'h08});
    @(negedge clk_i);
    upd_valid_i = 1'b0; tbl_rdata_i = 8'hB5;
    #1; chk("b2b_wd1", tbl_wdata_o, 8'h6A);
    @(negedge clk_i);
    tbl_rdata_i = 8'h00;
    #1; chk("b2b_rd2", port(), {1'b0, 1'b1, 1'b0, 6'h08});
    @(negedge clk_i);
    tbl_rdata_i = 8'h6A;
    #1; chk("b2b_wd2", tbl_wdata_o, 8'hD4);
    @(negedge clk_i);
    tbl_rdata_i = 8'h00;

    // starvation limit: 7 grants, read, write, grants resume
    lookup_req_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 64'h24; upd_taken_i = 1'b1;
    #1; chk("s_push_gnt", lookup_gnt_o, 1'b1);
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1; chk("starve_gnt", {lookup_gnt_o, tbl_req_o}, 2'b10);
      @(negedge clk_i);
    end
    #1; chk("starve_rd", port(), {1'b0, 1'b1, 1'b0, 6'h12});
    @(negedge clk_i);
    tbl_rdata_i = 8'h80;
    #1; chk("starve_wr", port(), {1'b0, 1'b1, 1'b1, 6'h12});
    chk("starve_wd", tbl_wdata_o, 8'h01);
    @(negedge clk_i);
    tbl_rdata_i = 8'h00;
    #1; chk("gnt_resume", lookup_gnt_o, 1'b1);
    @(negedge clk_i);

    // fill the FIFO under lookup pressure; no bypass on pop
    for (int i = 0; i < 4; i++) begin
      upd_valid_i = 1'b1; upd_pc_i = 64'((32 + i) * 2);
      #1; chk("fill_rdy", upd_ready_o, 1'b1);
      @(negedge clk_i);
    end
    upd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("full_gnt", {lookup_gnt_o, upd_ready_o}, 2'b10);
      @(negedge clk_i);
    end
    #1; chk("full_rd", port(), {1'b0, 1'b1, 1'b0, 6'h20});
    chk("full_rd_rdy", upd_ready_o, 1'b0);
    @(negedge clk_i);
    #1; chk("full_wr", port(), {1'b0, 1'b1, 1'b1, 6'h20});
    chk("full_wr_rdy", upd_ready_o, 1'b0);
    @(negedge clk_i);
    #1; chk("pop_rdy", {upd_ready_o, lookup_gnt_o}, 2'b11);
    @(negedge clk_i);

    // flush on a WR cycle with entries still queued
    lookup_req_i = 1'b0;
    #1; chk("pre_flush_rd", port(), {1'b0, 1'b1, 1'b0, 6'h21});
    @(negedge clk_i);
    flush_i = 1'b1;
    #1; chk("flush_wr_req", tbl_req_o, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b0;
    init_run("init_flush");
    #1; chk("flush_rdy", upd_ready_o, 1'b1);
    chk("flush_empty", tbl_req_o, 1'b0);

    // flush from IDLE refuses an update, then flush again at address 30
    flush_i = 1'b1; upd_valid_i = 1'b1; upd_pc_i = 64'h10;
    #1; chk("flush_no_acc", upd_ready_o, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b0; upd_valid_i = 1'b0;
    repeat (30) @(negedge clk_i);
    #1; chk("addr30", tbl_addr_o, 6'd30);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; lookup_req_i = 1'b1;
    init_run("init_restart");
    #1; chk("restart_done", {init_busy_o, upd_ready_o, tbl_req_o}, 3'b010);
    lookup_req_i = 1'b0;
    #1; chk("restart_empty", tbl_req_o, 1'b0);
    @(negedge clk_i);

    // reset while an update is being read discards it
    upd_valid_i = 1'b1; upd_pc_i = 64'h10; upd_taken_i = 1'b1;
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    #1; chk("mid_rd", port(), {1'b0, 1'b1, 1'b0, 6'h08});
    rst_ni = 1'b0;
    #1; chk("mid_rst", {init_busy_o, upd_ready_o, port()},
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    @(negedge clk_i);
    rst_ni = 1'b1;
    init_run("init_rst2");
    #1; chk("rst2_empty", {init_busy_o, tbl_req_o}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbp_update_ctrl.md
LBP_UPDATE_CTRL -- requirements
Module: lbp_update_ctrl

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 64, number of local-history-table (LHT) entries, power of two.
REQ-002 SHALL have parameter HIST_BITS, default 8, width of one LHT history entry.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of buffered pending updates.
REQ-004 SHALL have parameter STARVE_MAX, default 7, maximum consecutive lookup grants while an update is pending.
REQ-005 SHALL have parameter VLEN, default 64, PC width; IDX_W = log2(NR_ENTRIES).
REQ-006 SHALL have clk_i  in  1  the single clock; all state is on its rising edge.
REQ-007 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have flush_i  in  1  clear all LHT entries and pending updates.
REQ-009 SHALL have upd_valid_i, upd_ready_o, upd_pc_i, upd_taken_i  (in 1, out 1, in VLEN, in 1)  resolved-branch update handshake.
REQ-010 SHALL have lookup_req_i  in  1  and  lookup_gnt_o  out  1  prediction-read port request and grant.
REQ-011 SHALL have tbl_req_o, tbl_we_o  out  1 each; tbl_addr_o  out  IDX_W; tbl_wdata_o  out  HIST_BITS; tbl_rdata_i  in  HIST_BITS (valid one cycle after a read request).
REQ-012 SHALL have init_busy_o  out  1  high while the table clear is in progress.

Function
REQ-013 SHALL implement FSM states INIT, IDLE, WR; reset and flush state is INIT.
REQ-014 INIT: each cycle SHALL drive tbl_req_o=1, tbl_we_o=1, tbl_wdata_o=0, tbl_addr_o=init counter; the counter increments by 1, and after address NR_ENTRIES-1 the state SHALL be IDLE.
REQ-015 In INIT, init_busy_o SHALL be 1, and upd_ready_o and lookup_gnt_o SHALL be 0.
REQ-016 Update FIFO SHALL push when upd_valid_i and upd_ready_o are both high, storing index upd_pc_i[IDX_W:1] and upd_taken_i.
REQ-017 upd_ready_o SHALL equal (FIFO not full) and (state != INIT) and not flush_i; there is no full-FIFO bypass on a same-cycle pop.
REQ-018 In IDLE with FIFO non-empty, the update SHALL be selected when lookup_req_i=0 or starve count = STARVE_MAX; otherwise the lookup is granted.
REQ-019 When an update is selected, tbl_req_o SHALL be 1, tbl_we_o 0, tbl_addr_o = head index, lookup_gnt_o 0, and the next state SHALL be WR.
REQ-020 WR SHALL drive tbl_req_o=1, tbl_we_o=1, tbl_addr_o = head index, tbl_wdata_o = {tbl_rdata_i[HIST_BITS-2:0], head taken}, pop the FIFO, and return to IDLE.
REQ-021 In WR, lookup_gnt_o SHALL be 0.
REQ-022 A granted lookup SHALL set lookup_gnt_o=1 combinationally in the request cycle, with tbl_req_o=0; the lookup owns the port.
REQ-023 Starve count SHALL increment, saturating at STARVE_MAX, on each lookup grant while the FIFO is non-empty; it SHALL clear when an update is selected or the FIFO is empty.
REQ-024 Back-to-back updates to the same index SHALL see the previous write, because each read is issued only after the prior WR.
REQ-025 flush_i SHALL, in the next cycle, enter INIT with counter 0, empty the FIFO and clear the starve count.
REQ-026 A WR coinciding with flush_i SHALL be suppressed (tbl_req_o=0).
REQ-027 A flush during INIT SHALL restart the clear from address 0.
REQ-028 An update offered in the flush cycle SHALL not be accepted.

Reset
REQ-029 While rst_ni is low: state INIT, init counter 0, FIFO empty, starve count 0.
REQ-030 Outputs during reset SHALL be: init_busy_o=1, upd_ready_o=0, lookup_gnt_o=0, tbl_req_o=1, tbl_we_o=1, tbl_addr_o=0, tbl_wdata_o=0.
REQ-031 Reset assertion mid-operation SHALL discard all pending updates without any further table write.

Verification
REQ-032 Release reset, NR_ENTRIES=64 -> 64 write cycles at addresses 0..63 with data 0, then init_busy_o=0 and upd_ready_o=1 in the next cycle.
REQ-033 After init, push pc=0x8000_0010 taken=1 with lookup_req_i=0 -> read at address 0x08; with tbl_rdata_i=0x5A returned, the next cycle writes 0xB5 to address 0x08.
REQ-034 lookup_req_i held 1 with one update queued -> 7 consecutive lookup grants, then the update read in cycle 8 with lookup_gnt_o=0 for 2 cycles, then grants resume.
REQ-035 lookup_req_i held 1 and STARVE_MAX forced unreachable by pushing 4 updates in 4 cycles -> upd_ready_o=0 after the 4th push until the first pop.
REQ-036 Assert flush_i in a WR cycle -> no table write in that cycle; the FIFO empties and INIT restarts at address 0 for 64 cycles.
REQ-037 Assert flush_i at init address 30 -> the clear restarts at address 0 and init_busy_o stays 1 for 64 further cycles.
